// File: rtl/prime_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// prime_seq_ctrl_if
// Handshake bundle for the sequential primality controller.
//   in_valid / in_ready / number        : operand channel (producer -> ctrl)
//   out_valid / out_ready / prime / factor : result channel (ctrl -> consumer)
//   busy                                 : controller is not idle
// Modports:
//   master : the side that offers operands and consumes results
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface prime_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] number;
    logic             out_valid;
    logic             out_ready;
    logic             prime;
    logic [WIDTH-1:0] factor;
    logic             busy;

    modport master (
        output in_valid, number, out_ready,
        input  in_ready, out_valid, prime, factor, busy
    );

    modport slave (
        input  in_valid, number, out_ready,
        output in_ready, out_valid, prime, factor, busy
    );
endinterface

// File: rtl/prime_seq_ctrl.sv
// ---------------------------------------------------------------------------
// prime_seq_ctrl
// Multi-cycle primality test of one WIDTH-bit operand per transaction.
// Trial division by 2, then by odd d while d*d <= N. Each N mod d is formed by
// a bit-serial restoring remainder (WIDTH cycles), so no wide divider exists.
// Reports prime=1/factor=0 for primes, prime=0/factor=smallest divisor for
// composites, and prime=0/factor=0 for N < 2.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : prime_seq_ctrl_if.slave (operand/result valid-ready handshakes)
// ---------------------------------------------------------------------------
module prime_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    prime_seq_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRECHECK = 3'd1,
        TEST     = 3'd2,
        REM      = 3'd3,
        EVAL     = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH:0]     r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_prime;
    logic [WIDTH-1:0]   r_factor;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_n_nxt;
    logic [WIDTH-1:0]   w_d_nxt;
    logic [WIDTH:0]     w_rem_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_prime_nxt;
    logic [WIDTH-1:0]   w_factor_nxt;

    logic [2*WIDTH-1:0] w_dsq;
    logic [CW-1:0]      w_bitidx;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_dext;

    // d*d at double width so the loop bound never wraps near 2**WIDTH.
    assign w_dsq    = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
    // Remainder consumes N MSB first.
    assign w_bitidx = CW'(WIDTH - 1) - r_cnt;
    // r < d always holds between steps, so r fits WIDTH bits before the shift.
    assign w_shift  = {r_rem[WIDTH-1:0], r_n[w_bitidx]};
    assign w_dext   = {1'b0, r_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_n      <= '0;
            r_d      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_prime  <= 1'b0;
            r_factor <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_n      <= w_n_nxt;
            r_d      <= w_d_nxt;
            r_rem    <= w_rem_nxt;
            r_cnt    <= w_cnt_nxt;
            r_prime  <= w_prime_nxt;
            r_factor <= w_factor_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_n_nxt      = r_n;
        w_d_nxt      = r_d;
        w_rem_nxt    = r_rem;
        w_cnt_nxt    = r_cnt;
        w_prime_nxt  = r_prime;
        w_factor_nxt = r_factor;

        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_n_nxt     = bus.number;
                    w_state_nxt = PRECHECK;
                end
            end
            PRECHECK: begin
                if (r_n < WIDTH'(2)) begin
                    w_prime_nxt  = 1'b0;
                    w_factor_nxt = '0;
                    w_state_nxt  = DONE;
                end else if ((r_n == WIDTH'(2)) || (r_n == WIDTH'(3))) begin
                    w_prime_nxt  = 1'b1;
                    w_factor_nxt = '0;
                    w_state_nxt  = DONE;
                end else if (!r_n[0]) begin
                    w_prime_nxt  = 1'b0;
                    w_factor_nxt = WIDTH'(2);
                    w_state_nxt  = DONE;
                end else begin
                    w_d_nxt     = WIDTH'(3);
                    w_state_nxt = TEST;
                end
            end
            TEST: begin
                if (w_dsq > {{WIDTH{1'b0}}, r_n}) begin
                    w_prime_nxt  = 1'b1;
                    w_factor_nxt = '0;
                    w_state_nxt  = DONE;
                end else begin
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = REM;
                end
            end
            REM: begin
                if (w_shift >= w_dext) begin
                    w_rem_nxt = w_shift - w_dext;
                end else begin
                    w_rem_nxt = w_shift;
                end
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (r_rem == '0) begin
                    w_prime_nxt  = 1'b0;
                    w_factor_nxt = r_d;
                    w_state_nxt  = DONE;
                end else begin
                    w_d_nxt     = r_d + WIDTH'(2);
                    w_state_nxt = TEST;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.prime     = r_prime;
    assign bus.factor    = r_factor;

endmodule
